// File: rtl/sim_pkg.sv
// rtl/sim_pkg.sv - shared arbiter state type and memory width codes
//
// Purpose : types and constants shared by the memory arbiter and its bench.
// Contents: arb_state_t  - arbiter FSM states
//           MEM_W_*      - access width codes carried on d_width / m_width
package sim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        I_DROP = 2'd3
    } arb_state_t;

    localparam logic [2:0] MEM_W_BYTE  = 3'b000;
    localparam logic [2:0] MEM_W_HALF  = 3'b001;
    localparam logic [2:0] MEM_W_WORD  = 3'b010;
    localparam logic [2:0] MEM_W_BYTEU = 3'b100;
    localparam logic [2:0] MEM_W_HALFU = 3'b101;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-outstanding memory port
//
// Purpose : merges an instruction-fetch requester and a data requester onto
//           one memory port with at most one transaction in flight. Data has
//           priority unless fetch has lost STARVE_LIMIT consecutive arbitrations.
// Ports   : clk, rst                              clock, async active-high reset
//           if_req/if_addr -> if_gnt/if_rvalid/if_rdata      fetch side
//           d_req/d_we/d_width/d_addr/d_wdata ->
//                               d_gnt/d_rvalid/d_rdata        data side
//           halt, flush                           stop issuing / discard fetch
//           m_req/m_we/m_width/m_addr/m_wdata <- m_gnt/m_rvalid/m_rdata  memory
module mem_arbiter
    import sim_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_width,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        halt,
    input  logic        flush,
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_width,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state_q, state_d;
    logic [3:0] starve_q, starve_d;

    logic issue_ok;
    logic fetch_win;
    logic handshake;

    // ------------------------------------------------------------------
    // Arbitration and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        // A new request may go out when idle, or in the same cycle the
        // outstanding response returns (back-to-back issue).
        issue_ok  = !halt && ((state_q == IDLE) || m_rvalid);
        fetch_win = if_req && (!d_req || (starve_q == LIMIT));

        // rst gates every output so they read 0 while reset is held.
        m_req     = !rst && issue_ok && (if_req || d_req);
        handshake = m_req && m_gnt;
        if_gnt    = handshake && fetch_win;
        d_gnt     = handshake && !fetch_win;

        m_we    = 1'b0;
        m_width = 3'b000;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        if (m_req) begin
            if (fetch_win) begin
                m_width = MEM_W_WORD;
                m_addr  = if_addr;
            end else begin
                m_we    = d_we;
                m_width = d_width;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
        end

        // A flush in the same cycle as the fetch response kills the response.
        if_rvalid = !rst && m_rvalid && (state_q == I_WAIT) && !flush;
        d_rvalid  = !rst && m_rvalid && (state_q == D_WAIT);
        if_rdata  = rst ? 32'h0 : m_rdata;
        d_rdata   = rst ? 32'h0 : m_rdata;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A stray response arriving here (e.g. after reset) is dropped.
                if (handshake) begin
                    state_d = fetch_win ? I_WAIT : D_WAIT;
                end
            end
            I_WAIT: begin
                if (m_rvalid) begin
                    if (handshake) begin
                        state_d = fetch_win ? I_WAIT : D_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    state_d = I_DROP;
                end
            end
            D_WAIT, I_DROP: begin
                if (m_rvalid) begin
                    if (handshake) begin
                        state_d = fetch_win ? I_WAIT : D_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch starvation counter: counts cycles where fetch waited while a
    // data request was put on the bus; saturates at the limit.
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (m_req && !fetch_win && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import sim_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_width;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        halt, flush;
    logic        m_req, m_we;
    logic [2:0]  m_width;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .halt(halt), .flush(flush),
        .m_req(m_req), .m_we(m_we), .m_width(m_width), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; checks run after #1 settle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_width = 0; d_addr = 0;
        d_wdata = 0; halt = 0; flush = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic test_reset;
        clr_inputs();
        rst = 1; if_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
        m_rdata = 32'hA5A5_5A5A; if_addr = 32'h80;
        tick(); tick();
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%0b exp=0", m_req); end
        total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0b%0b exp=00", if_gnt, d_gnt); end
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b%0b exp=00", if_rvalid, d_rvalid); end
        total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
        clr_inputs();
        rst = 0;
        tick();
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h40; m_gnt = 1;
        #1;
        total++; if (m_req !== 1'b1 || if_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got req=%0b ig=%0b dg=%0b exp 1 1 0", m_req, if_gnt, d_gnt); end
        total++; if (m_addr !== 32'h40 || m_we !== 1'b0 || m_width !== 3'b010 || m_wdata !== 32'h0) begin bad++; $display("FAIL fetch_bus got addr=%h we=%0b w=%b wd=%h exp 40 0 010 0", m_addr, m_we, m_width, m_wdata); end
        tick();
        if_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0050_0093;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0050_0093) begin bad++; $display("FAIL fetch_resp got v=%0b d=%h exp 1 00500093", if_rvalid, if_rdata); end
        total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_d_rvalid got=%0b exp=0", d_rvalid); end
        tick();
        clr_inputs();
        #1;
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL fetch_idle got=%0d exp=%0d", dut.state_q, IDLE); end
    endtask

    task automatic test_priority;
        if_req = 1; if_addr = 32'h44;
        d_req = 1; d_we = 1; d_width = MEM_W_WORD; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        m_gnt = 1;
        #1;
        total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL prio_gnt got dg=%0b ig=%0b exp 1 0", d_gnt, if_gnt); end
        total++; if (m_we !== 1'b1 || m_addr !== 32'h100 || m_wdata !== 32'hDEAD_BEEF || m_width !== 3'b010) begin bad++; $display("FAIL prio_bus got we=%0b a=%h wd=%h w=%b", m_we, m_addr, m_wdata, m_width); end
        tick();
        d_req = 0; d_we = 0;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL prio_wait_no_issue got=%0b exp=0", m_req); end
        tick();
        m_rvalid = 1;
        #1;
        total++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL prio_ack got d=%0b i=%0b exp 1 0", d_rvalid, if_rvalid); end
        total++; if (if_gnt !== 1'b1 || m_addr !== 32'h44 || m_we !== 1'b0) begin bad++; $display("FAIL prio_b2b_fetch got ig=%0b a=%h we=%0b exp 1 44 0", if_gnt, m_addr, m_we); end
        tick();
        if_req = 0; m_rdata = 32'h1111_2222;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1111_2222) begin bad++; $display("FAIL prio_fetch_resp got v=%0b d=%h", if_rvalid, if_rdata); end
        tick();
        clr_inputs();
        tick();
    endtask

    task automatic test_starve;
        logic exp_ig;
        if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h300; d_width = MEM_W_WORD; m_gnt = 1;
        for (int i = 0; i < 6; i++) begin
            m_rvalid = (i > 0);
            m_rdata  = 32'h1000 + i;
            #1;
            exp_ig = (i == 4);
            total++; if (if_gnt !== exp_ig || d_gnt !== !exp_ig) begin bad++; $display("FAIL starve_arb%0d got ig=%0b dg=%0b exp ig=%0b", i, if_gnt, d_gnt, exp_ig); end
            if (i >= 1 && i <= 4) begin
                total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL starve_drv%0d got=%0b exp=1", i, d_rvalid); end
            end
            if (i == 5) begin
                total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1005) begin bad++; $display("FAIL starve_irv got v=%0b d=%h exp 1 1005", if_rvalid, if_rdata); end
            end
            tick();
        end
        if_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 1;
        #1;
        total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL starve_last_ack got=%0b exp=1", d_rvalid); end
        tick();
        clr_inputs();
        tick();
    endtask

    task automatic test_flush;
        if_req = 1; if_addr = 32'h400; m_gnt = 1;
        tick();
        if_req = 0; m_gnt = 0; flush = 1;
        #1;
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_nov got=%0b exp=0", if_rvalid); end
        tick();
        flush = 0;
        total++; if (dut.state_q !== I_DROP) begin bad++; $display("FAIL flush_drop_state got=%0d exp=%0d", dut.state_q, I_DROP); end
        m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
        #1;
        total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL flush_drop_rv got i=%0b d=%0b exp 0 0", if_rvalid, d_rvalid); end
        tick();
        m_rvalid = 0;
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL flush_idle got=%0d exp=%0d", dut.state_q, IDLE); end
        if_req = 1; if_addr = 32'h404; m_gnt = 1;
        #1;
        total++; if (if_gnt !== 1'b1 || m_addr !== 32'h404) begin bad++; $display("FAIL flush_refetch got ig=%0b a=%h", if_gnt, m_addr); end
        tick();
        if_req = 0; m_gnt = 0; m_rvalid = 1; flush = 1; m_rdata = 32'h0BAD;
        #1;
        total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_same_cycle got=%0b exp=0", if_rvalid); end
        tick();
        clr_inputs();
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL flush_same_idle got=%0d exp=%0d", dut.state_q, IDLE); end
        tick();
    endtask

    task automatic test_reset_mid;
        d_req = 1; d_we = 0; d_addr = 32'h500; d_width = MEM_W_HALF; m_gnt = 1;
        #1;
        total++; if (d_gnt !== 1'b1 || m_width !== MEM_W_HALF) begin bad++; $display("FAIL rstmid_gnt got dg=%0b w=%b", d_gnt, m_width); end
        tick();
        m_rdata = 32'h0000_1234; rst = 1;
        #1;
        total++; if (m_req !== 1'b0 || d_gnt !== 1'b0 || m_addr !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_outputs got req=%0b dg=%0b a=%h rd=%h exp all 0", m_req, d_gnt, m_addr, d_rdata); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state_q, IDLE); end
        tick();
        rst = 0; d_req = 0; m_gnt = 0; m_rvalid = 1;
        #1;
        total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_late got d=%0b i=%0b exp 0 0", d_rvalid, if_rvalid); end
        tick();
        clr_inputs();
        tick();
    endtask

    task automatic test_halt;
        if_req = 1; if_addr = 32'h600; m_gnt = 1;
        tick();
        halt = 1; if_addr = 32'h604; d_req = 1; d_addr = 32'h700;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL halt_wait_req got=%0b exp=0", m_req); end
        tick();
        m_rvalid = 1; m_rdata = 32'h6666;
        #1;
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h6666 || m_req !== 1'b0) begin bad++; $display("FAIL halt_resp got v=%0b d=%h req=%0b exp 1 6666 0", if_rvalid, if_rdata, m_req); end
        tick();
        m_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (m_req !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin bad++; $display("FAIL halt_hold%0d got req=%0b", i, m_req); end
            tick();
        end
        halt = 0; m_gnt = 0;
        #1;
        total++; if (m_req !== 1'b1 || m_addr !== 32'h700) begin bad++; $display("FAIL halt_release got req=%0b a=%h exp 1 700", m_req, m_addr); end
        tick();
        clr_inputs();
        tick();
    endtask

    initial begin
        clr_inputs();
        rst = 1;
        test_reset();
        test_fetch();
        test_priority();
        test_starve();
        test_flush();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost fetch cycles before fetch gets priority (1..15).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_we  in  1  data write.
- d_width  in  3  access width code, passed through unchanged.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data read data or write ack valid.
- d_rdata  out  32  data read data.
- halt  in  1  exit reached; stop issuing.
- flush  in  1  taken branch; discard fetch response.
- m_req  out  1  unified memory request.
- m_we  out  1  memory write.
- m_width  out  3  memory width.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_gnt  in  1  memory accepts request.
- m_rvalid  in  1  memory response/ack.
- m_rdata  in  32  memory read data.

Function
REQ-003 SHALL keep at most one transaction outstanding; FSM states IDLE, I_WAIT, D_WAIT, I_DROP.
REQ-004 SHALL drive m_req only when halt=0, the state is IDLE or m_rvalid=1 in a WAIT/DROP state, and (if_req or d_req).
REQ-005 SHALL select data over fetch, unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-006 SHALL drive m_we/m_width/m_addr/m_wdata combinationally from the winner; a fetch drives m_we=0, m_width=3'b010, m_wdata=0.
REQ-007 SHALL assert if_gnt/d_gnt = m_req & m_gnt & winner; the handshake moves to I_WAIT or D_WAIT next cycle.
REQ-008 SHALL return IDLE on m_rvalid when there is no same-cycle handshake, otherwise go to the new WAIT state (back-to-back).
REQ-009 SHALL set d_rvalid=m_rvalid in D_WAIT and if_rvalid=m_rvalid in I_WAIT; both 0 otherwise; rdata outputs follow m_rdata.
REQ-010 SHALL move I_WAIT to I_DROP on flush=1 without m_rvalid; with m_rvalid in the same cycle, the response is suppressed (if_rvalid=0).
REQ-011 SHALL, in I_DROP, consume m_rvalid with if_rvalid=0 and never forward it.
REQ-012 SHALL keep flush in IDLE/D_WAIT from affecting the state; the current if_req is still eligible.
REQ-013 SHALL make starve_cnt 4 bits, saturating at STARVE_LIMIT: +1 per cycle with if_req=1 and m_req issued for data, cleared on fetch grant or if_req=0.
REQ-014 SHALL keep outstanding transactions completing normally under halt; only new issue is blocked.
REQ-015 SHALL keep requests that are not granted unlatched; requesters hold req/addr until gnt.

Reset
REQ-016 SHALL, on rst=1 (asynchronous, any state, including mid-transaction), force state IDLE, starve_cnt 0, and all outputs 0 while asserted.
REQ-017 SHALL drop a memory response arriving after reset release in IDLE, with no rvalid.

Structure
REQ-018 SHALL put arb_state_t (IDLE, I_WAIT, D_WAIT, I_DROP), MEM_W_WORD=3'b010 and the width-code constants in shared package sim_pkg.
REQ-019 SHALL be a single module with no sub-module; the priority select and counter are inline.

Verification
REQ-020 Only if_req=1, addr 0x40, m_gnt=1, m_rvalid next cycle, data 0x00500093 -> if_gnt cycle 0, if_rvalid+rdata cycle 1.
REQ-021 if_req and d_req together (d_we=1, addr 0x100, wdata 0xDEADBEEF) -> d_gnt first, m_we=1; fetch granted after the ack.
REQ-022 d_req held 6 cycles, if_req held, STARVE_LIMIT=4 -> fetch granted on the 5th arbitration; starve_cnt then 0.
REQ-023 Fetch in I_WAIT, flush=1, m_rvalid one cycle later -> if_rvalid stays 0, state IDLE; the next fetch is granted normally.
REQ-024 rst pulsed in D_WAIT -> all outputs 0 immediately; late m_rvalid after release -> d_rvalid=0.
REQ-025 halt=1 with pending if_req/d_req -> m_req=0 indefinitely; the outstanding response is still delivered.
